// File: rtl/and_operand_sequencer_if.sv
// Purpose: byte stream in / operand pair out handshake bundle for the AND-unit
//          operand sequencer.
// Signals:
//   in_data/in_valid/in_ready   operand byte stream (A first, then B)
//   op_a/op_b/op_valid/op_ready operand pair presented to the AND stage
// Modports:
//   slave  - the sequencer (consumes the byte stream, produces the pair)
//   master - the environment (produces bytes, consumes the pair)
interface and_operand_sequencer_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_valid;
  logic             op_ready;

  modport slave (
    input  in_data, in_valid, op_ready,
    output in_ready, op_a, op_b, op_valid
  );

  modport master (
    output in_data, in_valid, op_ready,
    input  in_ready, op_a, op_b, op_valid
  );
endinterface

// File: rtl/and_operand_sequencer.sv
// Purpose: collects two bytes (A then B) from a valid/ready stream, holds them
//          as a stable operand pair for the AND stage, and counts consumed pairs.
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous, active-high reset
//   flush     synchronous abort of a partially/fully loaded pair
//   bus       and_operand_sequencer_if.slave (byte stream in, operand pair out)
//   op_count  pairs consumed, modulo 2^CNT_W
//   phase     debug view of the state: 0=WAIT_A 1=WAIT_B 2=PRESENT
module and_operand_sequencer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  and_operand_sequencer_if.slave bus,
  output logic [CNT_W-1:0]       op_count,
  output logic [1:0]             phase
);

  typedef enum logic [1:0] {
    WAIT_A  = 2'd0,
    WAIT_B  = 2'd1,
    PRESENT = 2'd2
  } state_t;

  state_t     state;
  state_t     state_d;
  logic       in_ready_d;
  logic       op_valid_d;
  logic [1:0] phase_d;

  // Next-state logic; flush overrides every transition.
  always_comb begin
    state_d = state;
    if (flush) begin
      state_d = WAIT_A;
    end else begin
      case (state)
        WAIT_A:  if (bus.in_valid) state_d = WAIT_B;
        WAIT_B:  if (bus.in_valid) state_d = PRESENT;
        PRESENT: if (bus.op_ready) state_d = WAIT_A;
        default: state_d = WAIT_A;
      endcase
    end
  end

  // Handshake outputs decoded from the next state so they can be registered
  // alongside the state itself (no input-to-output combinational path).
  always_comb begin
    in_ready_d = 1'b0;
    op_valid_d = 1'b0;
    phase_d    = 2'(state_d);
    case (state_d)
      WAIT_A, WAIT_B: in_ready_d = 1'b1;
      PRESENT:        op_valid_d = 1'b1;
      default:        in_ready_d = 1'b0;
    endcase
  end

  // State register with registered handshake/debug outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= WAIT_A;
      bus.in_ready <= 1'b1;
      bus.op_valid <= 1'b0;
      phase        <= 2'd0;
    end else begin
      state        <= state_d;
      bus.in_ready <= in_ready_d;
      bus.op_valid <= op_valid_d;
      phase        <= phase_d;
    end
  end

  // Operand capture and consume counter; a flush clears the pair but keeps the
  // count, and suppresses a concurrent consume.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.op_a <= '0;
      bus.op_b <= '0;
      op_count <= '0;
    end else if (flush) begin
      bus.op_a <= '0;
      bus.op_b <= '0;
    end else begin
      case (state)
        WAIT_A:  if (bus.in_valid) bus.op_a <= bus.in_data;
        WAIT_B:  if (bus.in_valid) bus.op_b <= bus.in_data;
        PRESENT: if (bus.op_ready) op_count <= op_count + CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_and_operand_sequencer.sv
// Purpose: directed self-checking bench for and_operand_sequencer.
// Status word compared each cycle: {phase, in_ready, op_valid, op_a, op_b, op_count}.
module tb_and_operand_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush;
  logic [7:0] op_count;
  logic [1:0] phase;

  int asserts  = 0;
  int failures = 0;

  logic [27:0] status;
  logic [27:0] exp_s;
  logic [7:0]  exp_count;

  and_operand_sequencer_if #(.WIDTH(8)) bus ();

  and_operand_sequencer #(.WIDTH(8), .CNT_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .bus      (bus),
    .op_count (op_count),
    .phase    (phase)
  );

  always #5 clk = ~clk;

  assign status = {phase, bus.in_ready, bus.op_valid, bus.op_a, bus.op_b, op_count};

  task automatic test_reset();
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hAB;
    @(negedge clk);
    exp_s = {2'd0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00};
    asserts++; if (status !== exp_s) begin failures++; $display("FAIL reset_hold0: status=%h expected=%h", status, exp_s); end
    @(negedge clk);
    asserts++; if (status !== exp_s) begin failures++; $display("FAIL reset_hold1: status=%h expected=%h", status, exp_s); end
    bus.in_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    asserts++; if (status !== exp_s) begin failures++; $display("FAIL reset_release: status=%h expected=%h", status, exp_s); end
  endtask

  task automatic test_basic();
    bus.op_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hF0;
    @(negedge clk);
    exp_s = {2'd1, 1'b1, 1'b0, 8'hF0, 8'h00, 8'h00};
    asserts++; if (status !== exp_s) begin failures++; $display("FAIL basic_a: status=%h expected=%h", status, exp_s); end
    bus.in_data = 8'h3C;
    @(negedge clk);
    exp_s = {2'd2, 1'b0, 1'b1, 8'hF0, 8'h3C, 8'h00};
    asserts++; if (status !== exp_s) begin failures++; $display("FAIL basic_present: status=%h expected=%h", status, exp_s); end
    bus.in_valid = 1'b0;
    @(negedge clk);
    exp_s = {2'd0, 1'b1, 1'b0, 8'hF0, 8'h3C, 8'h01};
    asserts++; if (status !== exp_s) begin failures++; $display("FAIL basic_consume: status=%h expected=%h", status, exp_s); end
  endtask

  task automatic test_stall();
    bus.op_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hAA;
    @(negedge clk);
    exp_s = {2'd1, 1'b1, 1'b0, 8'hAA, 8'h3C, 8'h01};
    asserts++; if (status !== exp_s) begin failures++; $display("FAIL stall_a: status=%h expected=%h", status, exp_s); end
    bus.in_data = 8'h55;
    @(negedge clk);
    exp_s = {2'd2, 1'b0, 1'b1, 8'hAA, 8'h55, 8'h01};
    asserts++; if (status !== exp_s) begin failures++; $display("FAIL stall_present: status=%h expected=%h", status, exp_s); end
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = (i % 2 == 0);
      bus.in_data  = 8'hFF;
      @(negedge clk);
      asserts++; if (status !== exp_s) begin failures++; $display("FAIL stall_hold%0d: status=%h expected=%h", i, status, exp_s); end
    end
    bus.in_valid = 1'b0;
    bus.op_ready = 1'b1;
    @(negedge clk);
    exp_s = {2'd0, 1'b1, 1'b0, 8'hAA, 8'h55, 8'h02};
    asserts++; if (status !== exp_s) begin failures++; $display("FAIL stall_consume: status=%h expected=%h", status, exp_s); end
  endtask

  task automatic test_gap();
    bus.op_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h81;
    @(negedge clk);
    exp_s = {2'd1, 1'b1, 1'b0, 8'h81, 8'h55, 8'h02};
    asserts++; if (status !== exp_s) begin failures++; $display("FAIL gap_a: status=%h expected=%h", status, exp_s); end
    bus.in_valid = 1'b0;
    bus.in_data  = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      asserts++; if (status !== exp_s) begin failures++; $display("FAIL gap_idle%0d: status=%h expected=%h", i, status, exp_s); end
    end
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h7E;
    @(negedge clk);
    exp_s = {2'd2, 1'b0, 1'b1, 8'h81, 8'h7E, 8'h02};
    asserts++; if (status !== exp_s) begin failures++; $display("FAIL gap_present: status=%h expected=%h", status, exp_s); end
    bus.in_valid = 1'b0;
    @(negedge clk);
    exp_s = {2'd0, 1'b1, 1'b0, 8'h81, 8'h7E, 8'h03};
    asserts++; if (status !== exp_s) begin failures++; $display("FAIL gap_consume: status=%h expected=%h", status, exp_s); end
  endtask

  task automatic test_flush();
    // Flush in WAIT_B with a concurrent (discarded) transfer.
    bus.op_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h12;
    @(negedge clk);
    exp_s = {2'd1, 1'b1, 1'b0, 8'h12, 8'h7E, 8'h03};
    asserts++; if (status !== exp_s) begin failures++; $display("FAIL flush_a: status=%h expected=%h", status, exp_s); end
    flush       = 1'b1;
    bus.in_data = 8'h99;
    @(negedge clk);
    exp_s = {2'd0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h03};
    asserts++; if (status !== exp_s) begin failures++; $display("FAIL flush_waitb: status=%h expected=%h", status, exp_s); end
    flush = 1'b0;
    // Flush in PRESENT with a concurrent op_ready: no count increment.
    bus.in_data = 8'h34;
    @(negedge clk);
    bus.in_data = 8'h56;
    @(negedge clk);
    exp_s = {2'd2, 1'b0, 1'b1, 8'h34, 8'h56, 8'h03};
    asserts++; if (status !== exp_s) begin failures++; $display("FAIL flush_pre_present: status=%h expected=%h", status, exp_s); end
    bus.in_valid = 1'b0;
    bus.op_ready = 1'b1;
    flush        = 1'b1;
    @(negedge clk);
    exp_s = {2'd0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h03};
    asserts++; if (status !== exp_s) begin failures++; $display("FAIL flush_present: status=%h expected=%h", status, exp_s); end
    flush = 1'b0;
    // Following pair is presented and consumed normally.
    bus.op_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h01;
    @(negedge clk);
    bus.in_data = 8'h02;
    @(negedge clk);
    exp_s = {2'd2, 1'b0, 1'b1, 8'h01, 8'h02, 8'h03};
    asserts++; if (status !== exp_s) begin failures++; $display("FAIL flush_next_pair: status=%h expected=%h", status, exp_s); end
    bus.in_valid = 1'b0;
    bus.op_ready = 1'b1;
    @(negedge clk);
    exp_s = {2'd0, 1'b1, 1'b0, 8'h01, 8'h02, 8'h04};
    asserts++; if (status !== exp_s) begin failures++; $display("FAIL flush_next_consume: status=%h expected=%h", status, exp_s); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] prev_b;
    exp_count    = 8'h04;
    prev_b       = 8'h02;
    bus.op_ready = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      a = 8'(i);
      b = ~8'(i);
      bus.in_data = a;
      @(negedge clk);
      exp_s = {2'd1, 1'b1, 1'b0, a, prev_b, exp_count};
      asserts++; if (status !== exp_s) begin failures++; $display("FAIL b2b_a%0d: status=%h expected=%h", i, status, exp_s); end
      bus.in_data = b;
      @(negedge clk);
      exp_s = {2'd2, 1'b0, 1'b1, a, b, exp_count};
      asserts++; if (status !== exp_s) begin failures++; $display("FAIL b2b_present%0d: status=%h expected=%h", i, status, exp_s); end
      @(negedge clk);
      exp_count = exp_count + 8'd1;
      exp_s = {2'd0, 1'b1, 1'b0, a, b, exp_count};
      asserts++; if (status !== exp_s) begin failures++; $display("FAIL b2b_consume%0d: status=%h expected=%h", i, status, exp_s); end
      prev_b = b;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    bus.op_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hC3;
    @(negedge clk);
    bus.in_data = 8'h3C;
    @(negedge clk);
    exp_s = {2'd2, 1'b0, 1'b1, 8'hC3, 8'h3C, 8'h04};
    asserts++; if (status !== exp_s) begin failures++; $display("FAIL areset_pre: status=%h expected=%h", status, exp_s); end
    bus.in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    exp_s = {2'd0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00};
    asserts++; if (status !== exp_s) begin failures++; $display("FAIL areset_immediate: status=%h expected=%h", status, exp_s); end
    #1 reset = 1'b0;
    @(negedge clk);
    asserts++; if (status !== exp_s) begin failures++; $display("FAIL areset_release: status=%h expected=%h", status, exp_s); end
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h5A;
    @(negedge clk);
    exp_s = {2'd1, 1'b1, 1'b0, 8'h5A, 8'h00, 8'h00};
    asserts++; if (status !== exp_s) begin failures++; $display("FAIL areset_resume: status=%h expected=%h", status, exp_s); end
    bus.in_valid = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    flush        = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    bus.op_ready = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_gap();
    test_flush();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
